// File: rtl/rr_request_arbiter.sv
// Round-robin arbiter: rotating-priority pick over a pointer-masked request vector with a bounded hold.
// Latency: 1 cycle from REQ to registered GRANT; owners are preempted only when others wait and MAX_HOLD is reached.
module rr_request_arbiter #(
  parameter int N        = 16,
  parameter int IDX_W    = 4,
  parameter int MAX_HOLD = 16
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic [N-1:0]     REQ,
  output logic [N-1:0]     GRANT,
  output logic [IDX_W-1:0] GRANT_IDX,
  output logic             GRANT_VALID,
  output logic [7:0]       HOLD_CNT
);

  typedef enum logic {IDLE, OWNED} state_t;

  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD - 1);

  state_t             state_q, state_d;
  logic [N-1:0]       grant_q, grant_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               vld_q, vld_d;
  logic [7:0]         hold_q, hold_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;

  logic [IDX_W:0]     pick_free;
  logic [IDX_W:0]     pick_pre;
  logic               owner_req;
  logic               others_req;
  logic               preempt;
  logic               load;
  logic [IDX_W-1:0]   sel_idx;

  // Returns {hit, idx}: lowest requester at or above ptr, else lowest overall.
  function automatic logic [IDX_W:0] pick_fn(input logic [N-1:0] req, input logic [IDX_W-1:0] ptr);
    logic             hit_hi, hit_any;
    logic [IDX_W-1:0] idx_hi, idx_any;
    hit_hi  = 1'b0;
    hit_any = 1'b0;
    idx_hi  = '0;
    idx_any = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        hit_any = 1'b1;
        idx_any = IDX_W'(i);
        if (i >= int'(ptr)) begin
          hit_hi = 1'b1;
          idx_hi = IDX_W'(i);
        end
      end
    end
    return hit_hi ? {1'b1, idx_hi} : {hit_any, idx_any};
  endfunction

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    idx_d      = idx_q;
    vld_d      = vld_q;
    hold_d     = hold_q;
    ptr_d      = ptr_q;
    load       = 1'b0;
    sel_idx    = '0;

    pick_free  = pick_fn(REQ, ptr_q);
    pick_pre   = pick_fn(REQ & ~grant_q, ptr_q);
    owner_req  = REQ[idx_q];
    others_req = |(REQ & ~grant_q);
    preempt    = (MAX_HOLD != 0) && (hold_q == HOLD_LIM) && others_req;

    case (state_q)
      IDLE: begin
        if (pick_free[IDX_W]) begin
          load    = 1'b1;
          sel_idx = pick_free[IDX_W-1:0];
        end
      end
      OWNED: begin
        if (owner_req) begin
          if (preempt) begin
            load    = 1'b1;
            sel_idx = pick_pre[IDX_W-1:0];
          end else begin
            hold_d = (hold_q == 8'hFF) ? hold_q : hold_q + 8'd1;
          end
        end else if (pick_free[IDX_W]) begin
          // Owner released: hand over on the same edge, no idle bubble.
          load    = 1'b1;
          sel_idx = pick_free[IDX_W-1:0];
        end else begin
          state_d = IDLE;
          grant_d = '0;
          idx_d   = '0;
          vld_d   = 1'b0;
          hold_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      state_d          = OWNED;
      grant_d          = '0;
      grant_d[sel_idx] = 1'b1;
      idx_d            = sel_idx;
      vld_d            = 1'b1;
      hold_d           = '0;
      ptr_d            = sel_idx + IDX_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      grant_q <= '0;
      idx_q   <= '0;
      vld_q   <= 1'b0;
      hold_q  <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      idx_q   <= idx_d;
      vld_q   <= vld_d;
      hold_q  <= hold_d;
      ptr_q   <= ptr_d;
    end
  end

  assign GRANT       = grant_q;
  assign GRANT_IDX   = idx_q;
  assign GRANT_VALID = vld_q;
  assign HOLD_CNT    = hold_q;

endmodule

// File: doc/rr_request_arbiter.md
Name: rr_request_arbiter

Overview:
Round-robin arbiter that shares one datapath resource (e.g. the memory/ALU-multiplier port) between N requesters. It uses a rotating-priority encode: a lowest-index-first priority encode over a pointer-masked request vector, falling back to the unmasked vector. It issues a registered one-hot grant plus a binary index. Grants are held while the owner keeps requesting, and a bounded hold counter forces rotation so no requester starves.

Parameters:
N, 16, number of requesters; legal values 4, 8 or 16.
IDX_W, 4, width of the grant index; must equal log2(N).
MAX_HOLD, 16, maximum consecutive cycles one owner may hold while others wait; 0 disables preemption; legal range 0..255.

Ports:
CLK  input  1  clock; all state updates on the rising edge.
RESET_N  input  1  asynchronous active-low reset.
REQ  input  N  request vector; bit i high means requester i wants the resource.
GRANT  output  N  one-hot grant, registered; all zero when idle.
GRANT_IDX  output  IDX_W  binary index of the current owner, registered; 0 when idle.
GRANT_VALID  output  1  high when GRANT holds exactly one bit.
HOLD_CNT  output  8  cycles the current owner has held the grant, saturating at 255.

Behaviour:
- Reset (RESET_N low, asynchronous): GRANT=0, GRANT_IDX=0, GRANT_VALID=0, HOLD_CNT=0, state IDLE, rotate pointer PTR=0. Reset mid-grant drops the grant immediately, not at the next edge. After RESET_N rises, the first grant is evaluated at the first rising edge.
- Pick function: select the lowest index i with REQ[i]=1 and i>=PTR. If there is none, select the lowest index with REQ[i]=1. If REQ=0, there is no pick.
- States: IDLE, OWNED.
- IDLE: at an edge with REQ!=0, go to OWNED. At that edge GRANT=onehot(pick), GRANT_IDX=pick, GRANT_VALID=1, HOLD_CNT=0, PTR=(pick+1) mod N. Latency from REQ rising to GRANT is 1 cycle.
- OWNED, owner still requesting (REQ[GRANT_IDX]=1):
  - Grant held; HOLD_CNT increments, saturating at 255.
  - Preempt when MAX_HOLD!=0, HOLD_CNT==MAX_HOLD-1, and any other REQ bit is set. At that edge, re-pick with the owner's bit masked out, grant the new winner, HOLD_CNT=0, PTR=(winner+1) mod N.
  - If no other request is pending, the owner keeps the grant past MAX_HOLD and HOLD_CNT keeps counting.
- OWNED, owner drops REQ: at that edge, re-pick from current REQ (owner bit is already 0).
  - Winner present: grant it in the same edge (back-to-back hand-over, no idle bubble), HOLD_CNT=0, PTR updated.
  - No requests: go to IDLE and clear GRANT, GRANT_IDX, GRANT_VALID and HOLD_CNT.
- PTR wrap-around: PTR=(N-1)+1 wraps to 0.
- GRANT is always one-hot or zero. GRANT_VALID==|GRANT. GRANT_IDX matches the set GRANT bit.
- REQ is assumed synchronous to CLK. Bits may change in any cycle, and only the value at the sampling edge matters.
- Purely synchronous datapath apart from the reset; no combinational path from REQ to any output.

Test Plan:
All scenarios use N=4 and MAX_HOLD=4.
- Reset/idle: RESET_N=0, then 1 with REQ=0000 for 5 cycles -> GRANT=0000, GRANT_VALID=0, GRANT_IDX=0, HOLD_CNT=0 every cycle.
- Single request: REQ=0100 at edge t -> at t+1 GRANT=0100, GRANT_IDX=2, VALID=1; HOLD_CNT counts 0,1,2,3,4,5...; REQ->0000 -> next edge GRANT=0000, IDLE.
- Round-robin rotation: REQ=1111 held constant -> owners rotate 0,1,2,3,0. Each owner is granted for exactly 4 cycles via preemption at HOLD_CNT=3, with no idle gap between owners.
- Hand-over on release: owner 1 with REQ=0011; drop bit 1 at edge t -> at t+1 GRANT=0001 (pick wraps since PTR=2 and no req>=2), HOLD_CNT=0.
- Wrap and masking: PTR=3 (after grant to 2), REQ=1001 -> grant 3, then next pick grants 0.
- Asynchronous reset mid-grant: owner 2 at HOLD_CNT=2, pull RESET_N low between edges -> GRANT=0000 and VALID=0 immediately. After release with REQ=0100 -> grant 2, because PTR reset to 0.
